// File: rtl/q15_pkg.sv
// Shared Q15 constants, FSM state type and helpers for the Q-format pipeline.
// The multiplier and the saturating add/sub stage both import this package.
package q15_pkg;

  localparam int Q15_WIDTH     = 64;
  localparam int Q15_FRAC_BITS = 15;

  localparam logic [Q15_WIDTH-1:0] Q15_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [Q15_WIDTH-1:0] Q15_MIN = 64'h8000_0000_0000_0000;

  // Half an LSB of the Q result, added before the fractional bits are dropped.
  localparam logic [2*Q15_WIDTH-1:0] ROUND_CONST = 128'h4000;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    FINAL,
    DONE
  } q15_state_e;

  // Magnitude of a two's-complement value; -2^63 maps to 2^63, which still fits unsigned.
  function automatic logic [Q15_WIDTH-1:0] q15_abs(input logic [Q15_WIDTH-1:0] v);
    return v[Q15_WIDTH-1] ? (~v + 64'd1) : v;
  endfunction

endpackage

// File: rtl/q15_seq_multiplier_if.sv
// Operand/result handshake bundle of the Q15 sequential multiplier.
// master = upstream producer/downstream consumer side, slave = multiplier.
interface q15_seq_multiplier_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_op;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_res;
  logic        out_overflow;
  logic        out_op;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_res, out_overflow, out_op
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_res, out_overflow, out_op
  );
endinterface

// File: rtl/q15_saturate.sv
// Combinational Q-format saturation: unsigned magnitude plus sign to a signed
// 64-bit result, clamping at Q15_MAX / Q15_MIN and flagging overflow.
module q15_saturate
  import q15_pkg::*;
(
  input  logic [112:0]          mag,
  input  logic                  sign,
  output logic [Q15_WIDTH-1:0]  res,
  output logic                  overflow
);

  logic [112:0] limit;

  // Negative results reach one further than positive ones: |MIN| = MAX + 1.
  assign limit    = {49'd0, (sign ? Q15_MIN : Q15_MAX)};
  assign overflow = (mag > limit);

  always_comb begin
    if (overflow) begin
      res = sign ? Q15_MIN : Q15_MAX;
    end else begin
      res = sign ? (~mag[Q15_WIDTH-1:0] + 64'd1) : mag[Q15_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/q15_seq_multiplier.sv
// Multi-cycle signed Q15 shift-add multiplier with saturation and op-tag passthrough.
// Optional build macro Q15_MUL_ROUND_EN: round half away from zero instead of truncating.
module q15_seq_multiplier
  import q15_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  q15_seq_multiplier_if.slave bus
);

  localparam int ITER  = Q15_WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);

  q15_state_e       state_q, state_d;
  logic [127:0]     acc_q, acc_d;
  logic [127:0]     a_sh_q, a_sh_d;
  logic [63:0]      b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             op_q, op_d;
  logic [63:0]      res_q, res_d;
  logic             ovf_q, ovf_d;
  logic             out_op_q, out_op_d;

  logic [127:0]     pp;
  logic [127:0]     acc_fin;
  logic [63:0]      sat_res;
  logic             sat_ovf;
  logic             unused_frac;

  // Partial product of the current multiplier digit, built from shifted adds only.
  always_comb begin
    pp = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_sh_q[j]) pp = pp + (a_sh_q << j);
    end
  end

`ifdef Q15_MUL_ROUND_EN
  assign acc_fin = acc_q + ROUND_CONST;
`else
  assign acc_fin = acc_q;
`endif

  // The dropped fractional bits only matter through the rounding carry.
  assign unused_frac = ^acc_fin[Q15_FRAC_BITS-1:0];

  q15_saturate u_sat (
    .mag      (acc_fin[127:Q15_FRAC_BITS]),
    .sign     (sign_q),
    .res      (sat_res),
    .overflow (sat_ovf)
  );

  // NOTE: every comb output gets its hold value first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    op_d     = op_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    out_op_d = out_op_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = {64'd0, q15_abs(bus.in_a)};
          b_sh_d  = q15_abs(bus.in_b);
          sign_d  = bus.in_a[63] ^ bus.in_b[63];
          op_d    = bus.in_op;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        acc_d  = acc_q + pp;
        a_sh_d = a_sh_q << BITS_PER_CYCLE;
        b_sh_d = b_sh_q >> BITS_PER_CYCLE;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITER - 1)) state_d = FINAL;
      end
      FINAL: begin
        res_d    = sat_res;
        ovf_d    = sat_ovf;
        out_op_d = op_q;
        state_d  = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from the same pre-edge values.
  // NOTE: the accumulator and operand registers are reset too, so an aborted op leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      op_q     <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      out_op_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      op_q     <= op_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      out_op_q <= out_op_d;
    end
  end

  assign bus.in_ready     = (state_q == IDLE);
  assign bus.out_valid    = (state_q == DONE);
  assign bus.out_res      = res_q;
  assign bus.out_overflow = ovf_q;
  assign bus.out_op       = out_op_q;

endmodule

// File: doc/q15_seq_multiplier.md
Name: q15_seq_multiplier

Overview:
Multi-cycle signed Q-format multiplier: 64-bit operands, 15 fractional bits. Produces a saturated 64-bit Q product plus an overflow flag. Sits directly upstream of the Q15 saturating add/sub stage and supplies its operand. An add/sub tag rides through with each operation so the adder's op select stays aligned with its data. Shift-add datapath, no DSP multiplier inferred.

Parameters:
BITS_PER_CYCLE, 1, multiplier bits consumed per iteration; legal values 1, 2, 4, 8; must divide 64.
ITER (localparam), 64/BITS_PER_CYCLE, iteration count.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand handshake valid
in_ready  output  1  high only in IDLE
in_a  input  64  signed Q operand a
in_b  input  64  signed Q operand b
in_op  input  1  tag: 0 add, 1 subtract; passed through untouched
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_res  output  64  signed saturated Q product
out_overflow  output  1  product saturated
out_op  output  1  captured in_op

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_res=0, out_overflow=0, out_op=0, all internal registers 0. Reset asserted mid-operation aborts immediately; the in-flight result is never emitted.
- States: IDLE -> MUL -> FINAL -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&in_ready, capture the operands:
  - |a| and |b| as 64-bit unsigned; |-2^63| = 2^63 fits.
  - sign = a[63]^b[63]; the op tag.
  - Clear the 128-bit accumulator and the iteration counter. Go to MUL.
- MUL: each cycle consumes BITS_PER_CYCLE LSBs of |b|.
  - Accumulator += (|a| << shift) x digit, then shift position advances.
  - After exactly ITER cycles go to FINAL.
- FINAL (one cycle):
  - mag = acc[127:15], truncated toward zero in magnitude.
  - Limit L = 2^63-1 if sign=0, 2^63 if sign=1.
  - If mag > L: overflow=1 and res = 0x7FFF_FFFF_FFFF_FFFF (positive) or 0x8000_0000_0000_0000 (negative).
  - Else overflow=0 and res = sign ? -mag : mag. A zero magnitude always gives +0, never a negative zero.
  - Register out_res, out_overflow, out_op. Go to DONE.
- DONE: out_valid=1; outputs held stable until out_ready. On out_valid&out_ready go to IDLE, out_valid=0 next cycle. out_res retains its last value.
- Latency: handshake at edge 0 -> out_valid high after edge ITER+1 (65 cycles at default). Throughput is one op per ITER+3 cycles at minimum. No overlap: in_ready=0 outside IDLE.
- in_valid while not in IDLE is ignored; the upstream must hold its data.
- out_ready high before DONE has no effect.

Optional Feature:
Q15_MUL_ROUND_EN.
- Defined: FINAL adds 2^14 to acc before taking [127:15]. This rounds half away from zero in magnitude. Saturation is checked after rounding.
- Undefined: truncation toward zero, as described above.
- Latency identical in both builds.

Decomposition:
- Package q15_pkg:
  - Q15_WIDTH=64, Q15_FRAC_BITS=15, Q15_MAX, Q15_MIN.
  - State enum {IDLE, MUL, FINAL, DONE}.
  - ROUND_CONST=2^14.
- Also shared with the adder side: Q15_MAX/Q15_MIN for identical saturation constants.
- One sub-module: q15_saturate.
  - Combinational: 113-bit magnitude + sign -> 64-bit result + overflow.
  - Reusable by later Q-format stages.
- Iteration FSM and accumulator stay in the top.

Test Plan:
- in_a=0xC000 (1.5), in_b=0x10000 (2.0), in_op=1 -> after 65 cycles out_res=0x18000, out_overflow=0, out_op=1.
- in_a=0xFFFF_FFFF_FFFF_8000 (-1.0), in_b=0x4000 (0.5) -> out_res=0xFFFF_FFFF_FFFF_C000, overflow=0.
- in_a=0x7FFF_FFFF_FFFF_FFFF, in_b=0x10000 -> out_res=0x7FFF_FFFF_FFFF_FFFF, overflow=1. Sign-flipped in_b=0xFFFF_FFFF_FFFF_0000 -> out_res=0x8000_0000_0000_0000, overflow=1.
- Rounding, in_a=0x1 with in_b=0x4000, then in_a=-1 with in_b=0x4000:
  - Without the macro: both results 0x0.
  - With Q15_MUL_ROUND_EN: 0x1 and 0xFFFF_FFFF_FFFF_FFFF respectively.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_res and out_op stable, in_ready=0 with in_valid=1 held; then out_ready=1 for one cycle -> in_ready=1 next cycle.
- Reset mid-operation: rst_n low at MUL iteration 10 -> outputs zero asynchronously, in_ready=1 after release. A new op (3.0 x 3.0 = 0x18000 x 0x18000) returns 0x48000 with no stale result emitted. Repeat with BITS_PER_CYCLE=4: latency 17 cycles.
